// File: rtl/neuron_mac_sequencer.sv
// Single-neuron controller: streams weights into the weight BRAM (LOAD) or walks
// both BRAMs and accumulates the signed dot product of weights and inputs (RUN).
module neuron_mac_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int ACCW  = 40
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            load_i,
    input  logic            ld_valid_i,
    input  logic [DW-1:0]   ld_data_i,
    output logic            ld_ready_o,
    output logic [AW-1:0]   w_addr_o,
    output logic [DW-1:0]   w_di_o,
    output logic            w_en_o,
    output logic            w_we_o,
    input  logic [DW-1:0]   w_do_i,
    output logic [AW-1:0]   x_addr_o,
    output logic            x_en_o,
    input  logic [DW-1:0]   x_do_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [ACCW-1:0] acc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    logic [DW-1:0]   w_di_q, w_di_d;
    logic            w_en_q, w_en_d;
    logic            w_we_q, w_we_d;
    logic [AW-1:0]   x_addr_q, x_addr_d;
    logic            x_en_q, x_en_d;
    logic            rvld_q, rvld_d;
    logic [ACCW-1:0] acc_q, acc_d;

    logic signed [2*DW-1:0] prod;
    logic [ACCW-1:0]        prod_ext;

    // BRAM outputs were captured on the falling edge, so they are stable here.
    assign prod     = $signed(w_do_i) * $signed(x_do_i);
    assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_addr_d   = w_addr_q;
        w_di_d     = w_di_q;
        w_en_d     = 1'b0;
        w_we_d     = 1'b0;
        x_addr_d   = x_addr_q;
        x_en_d     = 1'b0;
        rvld_d     = 1'b0;
        acc_d      = rvld_q ? acc_q + prod_ext : acc_q;
        ld_ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    if (load_i) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_RUN;
                        acc_d   = '0;
                    end
                end
            end
            S_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    w_addr_d = cnt_q;
                    w_di_d   = ld_data_i;
                    w_en_d   = 1'b1;
                    w_we_d   = 1'b1;
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                w_addr_d = cnt_q;
                x_addr_d = cnt_q;
                w_en_d   = 1'b1;
                x_en_d   = 1'b1;
                rvld_d   = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            // Last read issued in RUN is accumulated here via rvld_q.
            S_DRAIN: state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            w_addr_q <= '0;
            w_di_q   <= '0;
            w_en_q   <= 1'b0;
            w_we_q   <= 1'b0;
            x_addr_q <= '0;
            x_en_q   <= 1'b0;
            rvld_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_addr_q <= w_addr_d;
            w_di_q   <= w_di_d;
            w_en_q   <= w_en_d;
            w_we_q   <= w_we_d;
            x_addr_q <= x_addr_d;
            x_en_q   <= x_en_d;
            rvld_q   <= rvld_d;
            acc_q    <= acc_d;
        end
    end

    assign w_addr_o = w_addr_q;
    assign w_di_o   = w_di_q;
    assign w_en_o   = w_en_q;
    assign w_we_o   = w_we_q;
    assign x_addr_o = x_addr_q;
    assign x_en_o   = x_en_q;
    assign acc_o    = acc_q;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_FIN);

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Controller for one ANN neuron. It sequences a 28-entry negedge-read weight BRAM and a matching input-activation BRAM, and accumulates the signed dot product of weights and inputs. It also has a load mode that streams new weights into the weight BRAM through a valid/ready handshake. It sits between the layer scheduler, which issues START/LOAD, and the per-neuron weight/activation memories.

## Interface
- DEPTH, 28, number of weight/input pairs per neuron (BRAM entries 0..DEPTH-1)
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- DW, 16, weight/input data width, two's-complement signed
- ACCW, 40, accumulator width; must be >= 2*DW + AW
- CLK  in  1  single clock; all controller logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request, sampled only in IDLE
- LOAD  in  1  mode select, sampled with START: 1 = weight load, 0 = MAC run
- LD_VALID  in  1  load data valid
- LD_DATA  in  DW  weight word to write
- LD_READY  out  1  load data accepted when LD_VALID & LD_READY at a rising edge
- W_ADDR  out  AW  weight BRAM address
- W_DI  out  DW  weight BRAM write data
- W_EN  out  1  weight BRAM enable
- W_WE  out  1  weight BRAM write enable
- W_DO  in  DW  weight BRAM read data; registered by the BRAM on the falling edge
- X_ADDR  out  AW  input BRAM address
- X_EN  out  1  input BRAM enable; the controller never writes the input BRAM
- X_DO  in  DW  input BRAM read data; registered by the BRAM on the falling edge
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when a run or load completes
- ACC  out  ACCW  signed dot-product result; held until the next run starts

## Operation
- States: IDLE, LOAD, RUN, DRAIN, FIN.
- IDLE:
  - START & LOAD -> LOAD.
  - START & !LOAD -> RUN. ACC is cleared to 0 and the address counter is cleared to 0 on this transition.
- LOAD:
  - LD_READY = 1.
  - Each handshake registers W_ADDR <= cnt, W_DI <= LD_DATA, W_EN = W_WE = 1 for exactly one cycle, then increments cnt.
  - A cycle with no handshake drives W_EN = W_WE = 0.
  - The handshake on cnt = DEPTH-1 -> FIN. LD_READY drops in FIN.
- RUN:
  - Each cycle registers W_ADDR = X_ADDR = cnt, W_EN = X_EN = 1, W_WE = 0, and increments cnt.
  - When address DEPTH-1 is issued -> DRAIN.
  - A read-valid flag, delayed one cycle from each issue, gates accumulation.
- Accumulate: on each rising edge where the read-valid flag is set, ACC <= ACC + sext(W_DO * X_DO). The product is a signed DW x DW multiply to 2*DW bits, sign-extended to ACCW.
- Overflow: none is possible when ACCW >= 2*DW + AW, so no saturation logic is implemented.
- DRAIN: W_EN = X_EN = 0. The final product (address DEPTH-1) is accumulated in this cycle, then -> FIN.
- FIN: DONE = 1 for one cycle -> IDLE.
- START in any state other than IDLE is ignored. LOAD is don't-care outside the START cycle.
- LD_VALID outside LOAD is ignored; LD_READY stays 0.

## Timing
- Reset values: LD_READY, W_EN, W_WE, X_EN, BUSY, DONE = 0; W_ADDR, X_ADDR, W_DI = 0; ACC = 0; state IDLE. All apply immediately on RST_N low, independent of CLK.
- Reset mid-RUN or mid-LOAD aborts the operation:
  - W_EN/W_WE drop asynchronously, so no partial write occurs at the next falling edge.
  - Already-written weights are not restored.
- BRAM read pipeline:
  - Address/enable registered at rising edge k.
  - BRAM samples at the falling edge after k.
  - W_DO/X_DO are stable and consumed at rising edge k+1.
- RUN latency, with the START edge as cycle 0:
  - Addresses 0..DEPTH-1 issued on cycles 1..DEPTH.
  - Accumulations on cycles 2..DEPTH+1.
  - DONE on cycle DEPTH+2; BUSY deasserts on the same edge DONE deasserts.
  - The result is final when DONE is high and held in IDLE.
- LOAD timing:
  - Write for handshake n lands at the falling edge after the handshake edge.
  - DONE is asserted on the cycle after the last handshake.
  - With LD_VALID held high, total duration is DEPTH+1 cycles after START.
- Back-to-back: START may be asserted on the cycle DONE is high. It is ignored because the state is FIN; the earliest accepted START is the cycle after DONE.
- The W_DO value during write cycles is undefined and never consumed.

## Test plan
- Reset, no START: all outputs 0, BUSY = 0, no BRAM enable for 50 cycles. Assert RST_N low mid-RUN at cycle 10 -> W_EN/X_EN fall without a clock edge, ACC = 0.
- LOAD with LD_VALID held high, data = 1..28: exactly 28 writes to W_ADDR 0..27, each with W_WE high for one cycle. DONE is asserted 29 cycles after START. Readback of the BRAM model matches 1..28.
- LOAD with LD_VALID toggling every other cycle: writes occur only on handshake cycles, addresses have no gaps, and DONE follows the 28th handshake.
- RUN with all weights = 1 and all inputs = 1: ACC = 28, DONE on cycle 30 after START, addresses 0..27 each appear exactly once.
- RUN with weights = -32768 and inputs = -32768 (every entry): ACC = 28 * 2^30 = 30064771072, no wrap. Then RUN with weights = 32767 and inputs = -32768: ACC = -28 * 1073709056.
- START pulsed while BUSY, and START on the DONE cycle: both ignored. A new START the following cycle clears ACC to 0 and runs normally.
